// File: rtl/l2_req_scheduler_if.sv
// l2_req_scheduler_if: bundles the two core request/response channels, the
// downstream L2 request/response channels and the status outputs.
//   slave  : scheduler view (drives readies, responses, L2 request, status)
//   master : environment view (drives core requests and L2 handshakes)
interface l2_req_scheduler_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0_valid, req0_ready, req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req1_valid, req1_ready, req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              resp0_valid, resp0_err;
   logic [DATA_W-1:0] resp0_rdata;
   logic              resp1_valid, resp1_err;
   logic [DATA_W-1:0] resp1_rdata;
   logic              l2_req_valid, l2_req_ready, l2_we, l2_id;
   logic [ADDR_W-1:0] l2_addr;
   logic [DATA_W-1:0] l2_wdata;
   logic              l2_resp_valid;
   logic [DATA_W-1:0] l2_resp_rdata;
   logic              busy;
   logic [7:0]        drop_cnt;

   modport slave (
      input  req0_valid, req0_addr, req0_we, req0_wdata,
      input  req1_valid, req1_addr, req1_we, req1_wdata,
      input  l2_req_ready, l2_resp_valid, l2_resp_rdata,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_rdata, resp0_err,
      output resp1_valid, resp1_rdata, resp1_err,
      output l2_req_valid, l2_addr, l2_we, l2_wdata, l2_id,
      output busy, drop_cnt
   );

   modport master (
      output req0_valid, req0_addr, req0_we, req0_wdata,
      output req1_valid, req1_addr, req1_we, req1_wdata,
      output l2_req_ready, l2_resp_valid, l2_resp_rdata,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_rdata, resp0_err,
      input  resp1_valid, resp1_rdata, resp1_err,
      input  l2_req_valid, l2_addr, l2_we, l2_wdata, l2_id,
      input  busy, drop_cnt
   );
endinterface

// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler: two-core round-robin scheduler onto a single L2 port with
// one transaction outstanding at a time.
//   clk, rst : clock and synchronous active-high reset
//   bus      : l2_req_scheduler_if.slave (core requests/responses, L2 channels,
//              busy and saturating drop_cnt of discarded L2 responses)
// Optional feature: define L2_SCHED_TIMEOUT_EN to enable the WAIT watchdog,
// which returns an error response after TIMEOUT_CYC cycles without a reply.
module l2_req_scheduler #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input logic              clk,
   input logic              rst,
   l2_req_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYC out of range 2..255");
   end

   state_t            state;
   logic              last_grant, id_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [7:0]        drop_q;
   logic              gnt0, gnt1, issue, resp_on, r0, r1, err;

   // Tie goes to the master that did not win last time.
   assign gnt1 = state == IDLE && !rst && bus.req1_valid && (!bus.req0_valid || !last_grant);
   assign gnt0 = state == IDLE && !rst && bus.req0_valid && !gnt1;

`ifdef L2_SCHED_TIMEOUT_EN
   logic       err_q;
   logic [7:0] timer;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         drop_q     <= '0;
`ifdef L2_SCHED_TIMEOUT_EN
         err_q      <= 1'b0;
         timer      <= '0;
`endif
      end else begin
         // Any L2 response outside WAIT has no owner and is discarded.
         if (bus.l2_resp_valid && state != WAIT && drop_q != 8'hff)
            drop_q <= drop_q + 8'd1;
         case (state)
            IDLE:
               if (gnt0 || gnt1) begin
                  addr_q     <= gnt1 ? bus.req1_addr : bus.req0_addr;
                  we_q       <= gnt1 ? bus.req1_we : bus.req0_we;
                  wdata_q    <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
                  id_q       <= gnt1;
                  last_grant <= gnt1;
                  state      <= ISSUE;
               end
            ISSUE:
               if (bus.l2_req_ready) begin
                  state <= WAIT;
`ifdef L2_SCHED_TIMEOUT_EN
                  timer <= '0;
`endif
               end
            WAIT:
               if (bus.l2_resp_valid) begin
                  rdata_q <= bus.l2_resp_rdata;
                  state   <= RESP;
`ifdef L2_SCHED_TIMEOUT_EN
                  err_q   <= 1'b0;
               end else if (timer == 8'(TIMEOUT_CYC - 1)) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= RESP;
               end else begin
                  timer   <= timer + 8'd1;
`endif
               end
            default: state <= IDLE;
         endcase
      end
   end

   assign issue   = state == ISSUE && !rst;
   assign resp_on = state == RESP && !rst;
   assign r0      = resp_on && !id_q;
   assign r1      = resp_on && id_q;

   assign bus.req0_ready   = gnt0;
   assign bus.req1_ready   = gnt1;
   assign bus.l2_req_valid = issue;
   assign bus.l2_addr      = issue ? addr_q : '0;
   assign bus.l2_we        = issue && we_q;
   assign bus.l2_wdata     = issue ? wdata_q : '0;
   assign bus.l2_id        = issue && id_q;
   assign bus.resp0_valid  = r0;
   assign bus.resp0_rdata  = r0 ? rdata_q : '0;
   assign bus.resp0_err    = r0 && err;
   assign bus.resp1_valid  = r1;
   assign bus.resp1_rdata  = r1 ? rdata_q : '0;
   assign bus.resp1_err    = r1 && err;
   assign bus.busy         = state != IDLE && !rst;
   assign bus.drop_cnt     = rst ? 8'd0 : drop_q;
endmodule

// File: tb/tb_l2_req_scheduler.sv
// tb_l2_req_scheduler: directed table-driven bench for l2_req_scheduler.
module tb_l2_req_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   l2_req_scheduler_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   l2_req_scheduler #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] a0, a1, wd;
      logic        we;
      int          rdly;
      logic [31:0] rdata;
      logic        exp_id;
      logic [31:0] exp_addr, exp_wdata;
      logic        exp_we;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_we = 0; bus.req0_wdata = 0;
      bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_we = 0; bus.req1_wdata = 0;
      bus.l2_req_ready = 0; bus.l2_resp_valid = 0; bus.l2_resp_rdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, 32'(bus.busy), 0);
      chk({tag, " drop_cnt"}, 32'(bus.drop_cnt), 0);
      chk({tag, " l2_req_valid"}, 32'(bus.l2_req_valid), 0);
      chk({tag, " l2_fields"}, bus.l2_addr | bus.l2_wdata | 32'({bus.l2_we, bus.l2_id}), 0);
      chk({tag, " resp_valid"}, 32'({bus.resp1_valid, bus.resp0_valid}), 0);
      chk({tag, " resp_data"}, bus.resp0_rdata | bus.resp1_rdata | 32'({bus.resp0_err, bus.resp1_err}), 0);
      chk({tag, " ready"}, 32'({bus.req1_ready, bus.req0_ready}), 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      bus.req0_valid = v.mask[0]; bus.req0_addr = v.a0; bus.req0_wdata = v.wd;  bus.req0_we = v.we;
      bus.req1_valid = v.mask[1]; bus.req1_addr = v.a1; bus.req1_wdata = ~v.wd; bus.req1_we = !v.we;
      #1;
      chk({t, " grant"}, 32'({bus.req1_ready, bus.req0_ready}), v.exp_id ? 2 : 1);
      tick();
      chk({t, " l2_req_valid"}, 32'(bus.l2_req_valid), 1);
      chk({t, " l2_addr"}, bus.l2_addr, v.exp_addr);
      chk({t, " l2_wdata"}, bus.l2_wdata, v.exp_wdata);
      chk({t, " l2_we/id"}, 32'({bus.l2_we, bus.l2_id}), 32'({v.exp_we, v.exp_id}));
      chk({t, " ready in ISSUE"}, 32'({bus.req1_ready, bus.req0_ready}), 0);
      for (int d = 0; d < v.rdly; d++) begin
         tick();
         chk({t, " stall valid"}, 32'(bus.l2_req_valid), 1);
         chk({t, " stall addr"}, bus.l2_addr, v.exp_addr);
         chk({t, " stall wdata"}, bus.l2_wdata, v.exp_wdata);
         chk({t, " stall ready"}, 32'({bus.req1_ready, bus.req0_ready}), 0);
      end
      bus.l2_req_ready = 1;
      tick();
      bus.l2_req_ready = 0;
      chk({t, " WAIT l2 idle"}, bus.l2_addr | 32'({bus.l2_req_valid, bus.l2_id, bus.l2_we}), 0);
      chk({t, " WAIT no resp"}, 32'({bus.resp1_valid, bus.resp0_valid}), 0);
      bus.l2_resp_valid = 1;
      bus.l2_resp_rdata = v.rdata;
      tick();
      bus.l2_resp_valid = 0;
      bus.l2_resp_rdata = 0;
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      chk({t, " resp valid"}, 32'({bus.resp1_valid, bus.resp0_valid}), v.exp_id ? 2 : 1);
      chk({t, " resp rdata"}, v.exp_id ? bus.resp1_rdata : bus.resp0_rdata, v.rdata);
      chk({t, " resp err"}, 32'({bus.resp1_err, bus.resp0_err}), 0);
      chk({t, " other rdata"}, v.exp_id ? bus.resp0_rdata : bus.resp1_rdata, 0);
      tick();
      chk({t, " back idle"}, 32'({bus.busy, bus.resp1_valid, bus.resp0_valid}), 0);
   endtask

   initial begin
      //              mask   a0        a1        wd            we rdly rdata         id  exp_addr  exp_wdata     exp_we
      tbl[0] = '{2'b11, 32'h200, 32'h300, 32'h11111111, 0, 0, 32'hA0A0A0A0, 0, 32'h200, 32'h11111111, 0};
      tbl[1] = '{2'b11, 32'h204, 32'h304, 32'h22222222, 1, 0, 32'h000000B1, 1, 32'h304, 32'hDDDDDDDD, 0};
      tbl[2] = '{2'b11, 32'h208, 32'h308, 32'h33333333, 0, 0, 32'h000000C2, 0, 32'h208, 32'h33333333, 0};
      tbl[3] = '{2'b11, 32'h20C, 32'h30C, 32'h44444444, 1, 0, 32'h000000D3, 1, 32'h30C, 32'hBBBBBBBB, 0};
      tbl[4] = '{2'b01, 32'h100, 32'h500, 32'h00000000, 0, 0, 32'hDEADBEEF, 0, 32'h100, 32'h00000000, 0};
      tbl[5] = '{2'b10, 32'h104, 32'h504, 32'h55555555, 0, 0, 32'h12345678, 1, 32'h504, 32'hAAAAAAAA, 1};
      tbl[6] = '{2'b11, 32'h108, 32'h508, 32'h66666666, 1, 5, 32'hCAFEF00D, 0, 32'h108, 32'h66666666, 1};
      tbl[7] = '{2'b01, 32'h10C, 32'h50C, 32'h77777777, 0, 2, 32'h0BADF00D, 0, 32'h10C, 32'h77777777, 0};
      tbl[8] = '{2'b11, 32'h110, 32'h510, 32'h88888888, 0, 0, 32'hFFFFFFFF, 1, 32'h510, 32'h77777777, 1};

      do_reset();
      chk_all_zero("reset");
      for (int i = 0; i < 9; i++) run_vec(tbl[i], i);
      chk("table drop_cnt", 32'(bus.drop_cnt), 0);

      // Reset while waiting for the L2 reply abandons the transaction.
      bus.req0_valid = 1; bus.req0_addr = 32'h400;
      tick();
      bus.req0_valid = 0;
      bus.l2_req_ready = 1;
      tick();
      bus.l2_req_ready = 0;
      chk("pre-abort busy", 32'(bus.busy), 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      chk_all_zero("abort");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort no resp", 32'({bus.resp1_valid, bus.resp0_valid, bus.busy}), 0);
      end
      bus.l2_resp_valid = 1; bus.l2_resp_rdata = 32'h99;
      tick();
      bus.l2_resp_valid = 0;
      chk("late resp no resp0", 32'({bus.resp1_valid, bus.resp0_valid}), 0);
      chk("late resp dropped", 32'(bus.drop_cnt), 1);

      // Stray responses in IDLE saturate the drop counter.
      for (int k = 1; k <= 300; k++) begin
         bus.l2_resp_valid = 1;
         tick();
         bus.l2_resp_valid = 0;
         tick();
         if (k == 253) chk("drop 254", 32'(bus.drop_cnt), 254);
         if (k == 254) chk("drop 255", 32'(bus.drop_cnt), 255);
      end
      chk("drop saturated", 32'(bus.drop_cnt), 255);
      chk("strays idle", 32'({bus.busy, bus.resp1_valid, bus.resp0_valid}), 0);

`ifdef L2_SCHED_TIMEOUT_EN
      do_reset();
      bus.req1_valid = 1; bus.req1_addr = 32'h600;
      tick();
      bus.req1_valid = 0;
      bus.l2_req_ready = 1;
      tick();
      bus.l2_req_ready = 0;
      for (int i = 0; i < 8; i++) begin
         chk("timeout waiting", 32'({bus.resp1_valid, bus.busy}), 1);
         tick();
      end
      chk("timeout resp1_valid", 32'(bus.resp1_valid), 1);
      chk("timeout resp1_err", 32'(bus.resp1_err), 1);
      chk("timeout rdata", bus.resp1_rdata, 0);
      tick();
      bus.l2_resp_valid = 1; bus.l2_resp_rdata = 32'h77;
      tick();
      bus.l2_resp_valid = 0;
      chk("timeout late drop", 32'(bus.drop_cnt), 1);

      bus.req0_valid = 1; bus.req0_addr = 32'h700;
      tick();
      bus.req0_valid = 0;
      bus.l2_req_ready = 1;
      tick();
      bus.l2_req_ready = 0;
      for (int i = 0; i < 7; i++) tick();
      bus.l2_resp_valid = 1; bus.l2_resp_rdata = 32'h5A5A5A5A;
      tick();
      bus.l2_resp_valid = 0;
      chk("expiry tie valid", 32'(bus.resp0_valid), 1);
      chk("expiry tie err", 32'(bus.resp0_err), 0);
      chk("expiry tie rdata", bus.resp0_rdata, 32'h5A5A5A5A);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
